// File: rtl/key_acc_pkg.sv
// key_acc_pkg: shared state and op encodings for the key accumulator.
package key_acc_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR} acc_op_t;
endpackage

// File: rtl/key_accumulator_if.sv
// key_accumulator_if: button, operand and LED-side signals of the accumulator.
interface key_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 8
);
    logic              accumulate_n;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data_in;
    logic [ACC_W-1:0]  acc_out;
    logic              overflow;
    logic              accum_pulse;
    modport master (output accumulate_n, mode, data_in, input acc_out, overflow, accum_pulse);
    modport slave  (input accumulate_n, mode, data_in, output acc_out, overflow, accum_pulse);
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: synchronises an active-low button and emits one pulse per debounced press.
module key_debouncer
    import key_acc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic          s1, key_s;
    deb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1    <= 1'b1;
            key_s <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            s1    <= key_n;
            key_s <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // The entry edge counts as the first stable sample, so the level is seen DEBOUNCE_CYCLES times.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_pulse = 1'b0;
        cnt_inc     = cnt + CW'(1);
        case (state)
            IDLE: if (!key_s) begin
                state_nxt = PRESS_WAIT;
                cnt_nxt   = '0;
            end
            PRESS_WAIT: if (key_s) state_nxt = IDLE;
            else begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == LAST) begin
                    state_nxt   = HELD;
                    press_pulse = 1'b1;
                end
            end
            HELD: if (key_s) begin
                state_nxt = RELEASE_WAIT;
                cnt_nxt   = '0;
            end
            RELEASE_WAIT: if (!key_s) state_nxt = HELD;
            else begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == LAST) state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: rtl/key_accumulator.sv
// key_accumulator: applies ADD/SUB/LOAD/CLEAR of the switch operand on each debounced press.
module key_accumulator
    import key_acc_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int ACC_W           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SATURATE        = 0
) (
    input logic               clk,
    input logic               reset_n,
    key_accumulator_if.slave  bus
);
    logic             press;
    logic [ACC_W-1:0] acc, acc_nxt, op, diff;
    logic [ACC_W:0]   sum;
    logic             ovf, ovf_nxt, pulse, borrow, sat;
    acc_op_t          m;
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (bus.accumulate_n),
        .press_pulse (press)
    );
    always_comb begin
        m       = acc_op_t'(bus.mode);
        sat     = (SATURATE != 0);
        op      = ACC_W'(bus.data_in);
        sum     = {1'b0, acc} + {1'b0, op};
        diff    = acc - op;
        borrow  = op > acc;
        acc_nxt = m == OP_ADD  ? ((sum[ACC_W] && sat) ? '1 : sum[ACC_W-1:0]) :
                  m == OP_SUB  ? ((borrow && sat) ? '0 : diff) :
                  m == OP_LOAD ? op : '0;
        ovf_nxt = m == OP_ADD  ? (ovf | sum[ACC_W]) :
                  m == OP_SUB  ? (ovf | borrow) :
                  m == OP_LOAD ? ovf : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc   <= '0;
            ovf   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= press;
            if (press) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
            end
        end
    end
    assign bus.acc_out     = acc;
    assign bus.overflow    = ovf;
    assign bus.accum_pulse = pulse;
endmodule

// File: tb/tb_key_accumulator.sv
// tb_key_accumulator: directed checks of a wrapping and a saturating accumulator driven in parallel.
module tb_key_accumulator;
    import key_acc_pkg::*;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] data = 8'h00;
    int n_assert = 0;
    int n_fail = 0;
    int pc0 = 0;
    int pc1 = 0;
    int p;
    always #5 clk = ~clk;
    key_accumulator_if #(.DATA_W(8), .ACC_W(8)) b0 ();
    key_accumulator_if #(.DATA_W(8), .ACC_W(8)) b1 ();
    assign b0.accumulate_n = key;
    assign b0.mode         = mode;
    assign b0.data_in      = data;
    assign b1.accumulate_n = key;
    assign b1.mode         = mode;
    assign b1.data_in      = data;
    key_accumulator #(.DATA_W(8), .ACC_W(8), .DEBOUNCE_CYCLES(4), .SATURATE(0)) u0 (
        .clk (clk), .reset_n (reset_n), .bus (b0)
    );
    key_accumulator #(.DATA_W(8), .ACC_W(8), .DEBOUNCE_CYCLES(4), .SATURATE(1)) u1 (
        .clk (clk), .reset_n (reset_n), .bus (b1)
    );
    // Pulse cycles counted away from the active edge; a 2-cycle pulse counts twice.
    always @(negedge clk) begin
        if (b0.accum_pulse) pc0++;
        if (b1.accum_pulse) pc1++;
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic press(input logic [1:0] m, input logic [7:0] d);
        int q0, q1;
        q0 = pc0;
        q1 = pc1;
        mode = m;
        data = d;
        key = 1'b0;
        tick(6);
        check("pulse_at_6", {31'd0, b0.accum_pulse}, 32'd1);
        key = 1'b1;
        tick(8);
        check("one_pulse_u0", pc0 - q0, 32'd1);
        check("one_pulse_u1", pc1 - q1, 32'd1);
    endtask
    initial begin
        tick(3);
        check("rst_acc", {24'd0, b0.acc_out}, 32'h00);
        check("rst_ovf", {31'd0, b0.overflow}, 32'd0);
        check("rst_pulse", {31'd0, b0.accum_pulse}, 32'd0);
        check("rst_acc_sat", {24'd0, b1.acc_out}, 32'h00);
        // Clean press: accept edge is the 6th after the fall.
        reset_n = 1'b1;
        mode = OP_ADD;
        data = 8'h05;
        key = 1'b0;
        tick(5);
        check("pulse_early", {31'd0, b0.accum_pulse}, 32'd0);
        check("acc_early", {24'd0, b0.acc_out}, 32'h00);
        tick(1);
        check("pulse_lat", {31'd0, b0.accum_pulse}, 32'd1);
        check("add_05", {24'd0, b0.acc_out}, 32'h05);
        tick(1);
        check("pulse_width", {31'd0, b0.accum_pulse}, 32'd0);
        p = pc0;
        tick(20);
        check("no_repeat", pc0 - p, 32'd0);
        key = 1'b1;
        tick(8);
        // Press bounce then release glitch.
        p = pc0;
        data = 8'h01;
        key = 1'b0;
        tick(2);
        key = 1'b1;
        tick(1);
        key = 1'b0;
        tick(12);
        key = 1'b1;
        tick(1);
        key = 1'b0;
        tick(1);
        key = 1'b1;
        tick(12);
        check("bounce_one_pulse", pc0 - p, 32'd1);
        check("bounce_acc", {24'd0, b0.acc_out}, 32'h06);
        press(OP_LOAD, 8'hFA);
        press(OP_ADD, 8'h0A);
        check("add_wrap", {24'd0, b0.acc_out}, 32'h04);
        check("add_wrap_ovf", {31'd0, b0.overflow}, 32'd1);
        check("add_sat", {24'd0, b1.acc_out}, 32'hFF);
        check("add_sat_ovf", {31'd0, b1.overflow}, 32'd1);
        press(OP_CLEAR, 8'h77);
        check("clr_acc", {24'd0, b0.acc_out}, 32'h00);
        check("clr_ovf", {31'd0, b0.overflow}, 32'd0);
        press(OP_LOAD, 8'h10);
        press(OP_SUB, 8'h03);
        check("sub_ok", {24'd0, b0.acc_out}, 32'h0D);
        check("sub_ok_ovf", {31'd0, b0.overflow}, 32'd0);
        press(OP_LOAD, 8'h03);
        press(OP_SUB, 8'h05);
        check("sub_wrap", {24'd0, b0.acc_out}, 32'hFE);
        check("sub_wrap_ovf", {31'd0, b0.overflow}, 32'd1);
        check("sub_sat", {24'd0, b1.acc_out}, 32'h00);
        check("sub_sat_ovf", {31'd0, b1.overflow}, 32'd1);
        press(OP_LOAD, 8'h42);
        check("load_acc", {24'd0, b0.acc_out}, 32'h42);
        check("load_keeps_ovf", {31'd0, b0.overflow}, 32'd1);
        press(OP_CLEAR, 8'h00);
        check("clr2_acc", {24'd0, b0.acc_out}, 32'h00);
        check("clr2_ovf", {31'd0, b0.overflow}, 32'd0);
        check("clr2_ovf_sat", {31'd0, b1.overflow}, 32'd0);
        press(OP_LOAD, 8'h55);
        press(OP_ADD, 8'hFF);
        check("pre_rst_acc", {24'd0, b0.acc_out}, 32'h54);
        check("pre_rst_ovf", {31'd0, b0.overflow}, 32'd1);
        // Reset during PRESS_WAIT, then release reset with the key still down.
        p = pc0;
        mode = OP_ADD;
        data = 8'h07;
        key = 1'b0;
        tick(4);
        reset_n = 1'b0;
        tick(2);
        check("rst_mid_no_pulse", pc0 - p, 32'd0);
        check("rst_mid_acc", {24'd0, b0.acc_out}, 32'h00);
        check("rst_mid_ovf", {31'd0, b0.overflow}, 32'd0);
        reset_n = 1'b1;
        tick(5);
        check("rst_held_early", pc0 - p, 32'd0);
        tick(1);
        check("rst_held_pulse", {31'd0, b0.accum_pulse}, 32'd1);
        check("rst_held_acc", {24'd0, b0.acc_out}, 32'h07);
        key = 1'b1;
        tick(8);
        // Operand changes just before the accept edge; that value is captured.
        p = pc0;
        data = 8'h01;
        key = 1'b0;
        tick(5);
        data = 8'h10;
        tick(1);
        check("edge_pulse", {31'd0, b0.accum_pulse}, 32'd1);
        check("edge_acc", {24'd0, b0.acc_out}, 32'h17);
        data = 8'h20;
        tick(1);
        check("edge_pulse_low", {31'd0, b0.accum_pulse}, 32'd0);
        check("edge_acc_hold", {24'd0, b0.acc_out}, 32'h17);
        key = 1'b1;
        tick(8);
        check("edge_one_pulse", pc0 - p, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
